// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and digit width for the serial subtractor
package sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  localparam int DIGIT_W = 2;
endpackage

// File: rtl/sub2_slice.sv
// sub2_slice: combinational 2-bit subtract-with-borrow digit
module sub2_slice
  import sub_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               br_in,
  output logic [DIGIT_W-1:0] d,
  output logic               br_out
);
  logic br_mid;
  always_comb begin
    d[0]   = a[0] ^ b[0] ^ br_in;
    br_mid = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br_in);
    d[1]   = a[1] ^ b[1] ^ br_mid;
    br_out = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & br_mid);
  end
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: a - b - b_in computed two bits per cycle behind valid/ready ports
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);
  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(DIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);
  generate
    if (WIDTH < DIGIT_W || WIDTH % DIGIT_W != 0) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be even and >= 2");
    end
  endgenerate
  sub_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
  logic br, bo, last, acc;
  logic [DIGIT_W-1:0] d;
  sub2_slice u_slice (
    .a(a_sh[DIGIT_W-1:0]),
    .b(b_sh[DIGIT_W-1:0]),
    .br_in(br),
    .d(d),
    .br_out(bo)
  );
  assign last = cnt == LAST;
  assign acc = in_valid && in_ready;
  // digits enter at the MSB end so the LSB digit lands at bit 0 after the last shift
  generate
    if (WIDTH == DIGIT_W) begin : g_one_digit
      assign res_nx = d;
    end else begin : g_multi_digit
      assign res_nx = {d, res[WIDTH-1:DIGIT_W]};
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = acc ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
    end else if (acc) begin
      a_sh <= a;
      b_sh <= b;
      br   <= b_in;
      cnt  <= '0;
      res  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT_W;
      b_sh <= b_sh >> DIGIT_W;
      br   <= bo;
      cnt  <= cnt + 1'b1;
      res  <= res_nx;
      if (last) begin
        diff  <= res_nx;
        b_out <= bo;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and model-checked tests for serial_subtractor (WIDTH 8 and 2)
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b0, b_in = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, b_out;
  logic [7:0] diff;
  logic in_valid2 = 1'b0, out_ready2 = 1'b0, b_in2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic in_ready2, out_valid2, b_out2;
  logic [1:0] diff2;
  int n_vec = 0, n_err = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out)
  );
  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .b_in(b_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .diff(diff2), .b_out(b_out2)
  );

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {8'd0, bi};
  endfunction

  task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic vbi,
                     output logic [8:0] res, output int lat);
    @(negedge clk);
    a = va; b = vb; b_in = vbi; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; a = 'x; b = 'x; b_in = 1'bx;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    res = {b_out, diff};
  endtask

  task automatic ack8(output logic [1:0] st);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    st = {out_valid, in_ready};
  endtask

  task automatic op2(input logic [1:0] va, input logic [1:0] vb, input logic vbi,
                     output logic [2:0] res, output int lat);
    @(negedge clk);
    a2 = va; b2 = vb; b_in2 = vbi; in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0; a2 = 'x; b2 = 'x; b_in2 = 1'bx;
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    res = {b_out2, diff2};
    out_ready2 = 1'b1;
    @(posedge clk);
    #1 out_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({in_ready, out_valid, b_out, diff} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset: got rdy=%b vld=%b bo=%b diff=%h want 1 0 0 00", in_ready, out_valid, b_out, diff);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [8:0] r;
    logic [1:0] st;
    int lat;
    op8(8'h5A, 8'h3C, 1'b0, r, lat);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_vec++;
    if (r !== 9'h01E) begin n_err++; $display("FAIL basic_result: got %h want 01e", r); end
    ack8(st);
    n_vec++;
    if (st !== 2'b01) begin n_err++; $display("FAIL basic_idle: got vld,rdy=%b want 01", st); end
  endtask

  task automatic test_borrow();
    logic [8:0] r;
    logic [1:0] st;
    int lat;
    op8(8'h00, 8'h01, 1'b0, r, lat);
    n_vec++;
    if (r !== 9'h1FF) begin n_err++; $display("FAIL borrow_0_minus_1: got %h want 1ff", r); end
    ack8(st);
    op8(8'hFF, 8'hFF, 1'b1, r, lat);
    n_vec++;
    if (r !== 9'h1FF) begin n_err++; $display("FAIL borrow_ff_ff_bin: got %h want 1ff", r); end
    ack8(st);
    op8(8'h00, 8'h00, 1'b1, r, lat);
    n_vec++;
    if (r !== 9'h1FF) begin n_err++; $display("FAIL borrow_0_0_bin: got %h want 1ff", r); end
    ack8(st);
    op8(8'hA5, 8'hA5, 1'b0, r, lat);
    n_vec++;
    if (r !== 9'h000) begin n_err++; $display("FAIL equal_operands: got %h want 000", r); end
    ack8(st);
  endtask

  task automatic test_backpressure();
    logic [8:0] r;
    logic [1:0] st;
    int lat;
    op8(8'h80, 8'h01, 1'b0, r, lat);
    n_vec++;
    if (r !== 9'h07F) begin n_err++; $display("FAIL bp_result: got %h want 07f", r); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 n_vec++;
      if ({out_valid, in_ready, b_out, diff} !== {1'b1, 1'b0, 1'b0, 8'h7F}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b bo=%b diff=%h want 1 0 0 7f", i, out_valid, in_ready, b_out, diff);
      end
    end
    ack8(st);
    n_vec++;
    if (st !== 2'b01) begin n_err++; $display("FAIL bp_release: got vld,rdy=%b want 01", st); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va[3] = '{8'h10, 8'h01, 8'hC3};
    logic [7:0] vb[3] = '{8'h01, 8'h02, 8'h42};
    logic       vi[3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] ex[3] = '{9'h00F, 9'h1FF, 9'h080};
    int acc_t[3];
    int cyc = 0, nacc = 0, nres = 0;
    out_ready = 1'b1;
    while (nres < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        n_vec++;
        if ({b_out, diff} !== ex[nres]) begin
          n_err++;
          $display("FAIL b2b_result%0d: got %h want %h", nres, {b_out, diff}, ex[nres]);
        end
        nres++;
      end
      if (nacc < 3) begin
        a = va[nacc]; b = vb[nacc]; b_in = vi[nacc]; in_valid = 1'b1;
        if (in_ready === 1'b1) begin
          acc_t[nacc] = cyc;
          nacc++;
        end
      end else in_valid = 1'b0;
    end
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (nres !== 3 || nacc !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got acc=%0d res=%0d want 3 3", nacc, nres);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (acc_t[i] - acc_t[i-1] !== 6) begin
          n_err++;
          $display("FAIL b2b_spacing%0d: got %0d want 6", i, acc_t[i] - acc_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h11; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 n_vec++;
    if ({in_ready, out_valid, b_out, diff} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL mid_run_reset: got rdy=%b vld=%b bo=%b diff=%h want 1 0 0 00", in_ready, out_valid, b_out, diff);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    n_vec++;
    if ({seen, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL post_reset: got seen_vld=%b rdy=%b want 0 1", seen, in_ready);
    end
  endtask

  task automatic test_random();
    logic [8:0] r, e;
    logic [1:0] st;
    logic [7:0] x, y;
    logic bi;
    int lat;
    for (int i = 0; i < 100; i++) begin
      x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
      e = ref8(x, y, bi);
      op8(x, y, bi, r, lat);
      n_vec++;
      if (r !== e || lat !== 4) begin
        n_err++;
        $display("FAIL random%0d %h-%h-%b: got %h lat %0d want %h lat 4", i, x, y, bi, r, lat, e);
      end
      ack8(st);
    end
  endtask

  task automatic test_w2_sweep();
    logic [2:0] r, e;
    int lat;
    for (int i = 0; i < 32; i++) begin
      e = {1'b0, i[4:3]} - {1'b0, i[2:1]} - {2'b0, i[0]};
      op2(i[4:3], i[2:1], i[0], r, lat);
      n_vec++;
      if (r !== e || lat !== 1) begin
        n_err++;
        $display("FAIL w2_case%0d: got %h lat %0d want %h lat 1", i, r, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_w2_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
